// File: rtl/interdevice_link_hub_pkg.sv
// Shared types for the inter-device link hub.
//   node_id_t    : 4-bit node address; BROADCAST_ID addresses every node.
//   flit_t       : {src_id, dst_id, payload[15:0], checksum[7:0]} (32 bits).
//   DROP_CNT_W   : width of the per-link discarded-flit counters.
//   flit_checksum: expected checksum byte of a flit (XOR of the three
//                  header/payload bytes).
package interdevice_link_hub_pkg;

  typedef logic [3:0] node_id_t;

  localparam node_id_t BROADCAST_ID = 4'hF;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    node_id_t    src_id;
    node_id_t    dst_id;
    logic [15:0] payload;
    logic [7:0]  checksum;
  } flit_t;

  function automatic logic [7:0] flit_checksum(input flit_t f);
    return {f.src_id, f.dst_id} ^ f.payload[15:8] ^ f.payload[7:0];
  endfunction

endpackage

// File: rtl/calculate_checksum_comb.sv
// Combinational checksum check for one flit.
// Ports:
//   flit        in  flit_t  flit under test
//   checksum_ok out 1       high when the carried checksum matches the content
module calculate_checksum_comb
  import interdevice_link_hub_pkg::*;
(
  input  flit_t flit,
  output logic  checksum_ok
);

  assign checksum_ok = (flit_checksum(flit) == flit.checksum);

endmodule

// File: rtl/interdevice_rx_fifo.sv
// Per-link receive FIFO with a combinational head read.
// Ports:
//   clk, rst   in   clock, asynchronous active-high reset
//   push       in   enqueue push_flit (ignored while full, even if popped)
//   push_flit  in   flit to enqueue
//   pop        in   dequeue head (ignored while empty)
//   head_flit  out  oldest stored flit
//   full/empty out  occupancy flags
module interdevice_rx_fifo
  import interdevice_link_hub_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  flit_t push_flit,
  input  logic  pop,
  output flit_t head_flit,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  flit_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // Full blocks a push outright; a same-cycle pop does not make room early.
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_flit = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_flit;
  end

endmodule

// File: rtl/interdevice_link_hub.sv
// Inter-device link hub: replicates the local TX stream onto every direct
// link and merges the inbound links into one local RX stream.
// Optional feature macro: INTERDEVICE_BROADCAST_ACCEPT_EN (accept flits
// addressed to BROADCAST_ID; otherwise they are dropped and counted).
//
// Handshake rule for every stream: a transfer happens on the rising cpuclk
// edge where valid and ready are both high; a source keeps valid (and its
// data) asserted until that transfer happens.
//
// Ports:
//   cpuclk, rst                  clock, asynchronous active-high reset
//   this_node_id                 local node address
//   interdevice_tx_*             local TX stream in (flit/valid, ready out)
//   interdevice_rx_*             merged RX stream out (flit/valid, ready in)
//   flit_rx / _valid / _ready    per-link inbound streams
//   flit_tx / _valid / _ready    outbound: shared flit bus, per-link valid/ready
//   drop_count                   per-link saturating count of discarded flits
module interdevice_link_hub
  import interdevice_link_hub_pkg::*;
#(
  parameter int NUM_LINKS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  cpuclk,
  input  logic                  rst,
  input  node_id_t              this_node_id,
  input  flit_t                 interdevice_tx_flit,
  input  logic                  interdevice_tx_valid,
  output logic                  interdevice_tx_ready,
  output flit_t                 interdevice_rx_flit,
  output logic                  interdevice_rx_valid,
  input  logic                  interdevice_rx_ready,
  input  flit_t                 flit_rx [NUM_LINKS],
  input  logic [NUM_LINKS-1:0]  flit_rx_valid,
  output logic [NUM_LINKS-1:0]  flit_rx_ready,
  output flit_t                 flit_tx,
  output logic [NUM_LINKS-1:0]  flit_tx_valid,
  input  logic [NUM_LINKS-1:0]  flit_tx_ready,
  output logic [DROP_CNT_W-1:0] drop_count [NUM_LINKS]
);

  localparam int PTR_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

  // ---------------- TX fan-out ----------------
  // sent[i] marks links that already took the current flit so it is not
  // delivered twice while slower links catch up.
  logic [NUM_LINKS-1:0] sent;

  assign flit_tx              = interdevice_tx_flit;
  assign flit_tx_valid        = {NUM_LINKS{interdevice_tx_valid}} & ~sent;
  assign interdevice_tx_ready = &(sent | flit_tx_ready);

  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      sent <= '0;
    end else if (interdevice_tx_valid && interdevice_tx_ready) begin
      sent <= '0;
    end else begin
      sent <= sent | (flit_tx_valid & flit_tx_ready);
    end
  end

  // ---------------- RX filtering ----------------
  logic [NUM_LINKS-1:0] full;
  logic [NUM_LINKS-1:0] empty;
  logic [NUM_LINKS-1:0] cs_ok;
  logic [NUM_LINKS-1:0] dst_ok;
  logic [NUM_LINKS-1:0] push;
  logic [NUM_LINKS-1:0] drop;
  logic [NUM_LINKS-1:0] pop;
  flit_t                head [NUM_LINKS];

  assign flit_rx_ready = ~full & {NUM_LINKS{~rst}};

  always_comb begin
    dst_ok = '0;
    push   = '0;
    drop   = '0;
    for (int k = 0; k < NUM_LINKS; k++) begin
`ifdef INTERDEVICE_BROADCAST_ACCEPT_EN
      dst_ok[k] = (flit_rx[k].dst_id == BROADCAST_ID) ||
                  (flit_rx[k].dst_id == this_node_id);
`else
      dst_ok[k] = (flit_rx[k].dst_id == this_node_id) &&
                  (flit_rx[k].dst_id != BROADCAST_ID);
`endif
      push[k] = flit_rx_valid[k] & flit_rx_ready[k] & cs_ok[k] & dst_ok[k];
      drop[k] = flit_rx_valid[k] & flit_rx_ready[k] & ~(cs_ok[k] & dst_ok[k]);
    end
  end

  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LINKS; k++) drop_count[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LINKS; k++) begin
        if (drop[k] && (drop_count[k] != '1))
          drop_count[k] <= drop_count[k] + DROP_CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_LINKS; g++) begin : g_link
    calculate_checksum_comb u_checksum (
      .flit        (flit_rx[g]),
      .checksum_ok (cs_ok[g])
    );

    interdevice_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (cpuclk),
      .rst       (rst),
      .push      (push[g]),
      .push_flit (flit_rx[g]),
      .pop       (pop[g]),
      .head_flit (head[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // ---------------- RX round-robin merge ----------------
  // Once a FIFO is offered it stays granted (locked) until the consumer
  // accepts, so the presented flit never changes under a stalled consumer.
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_q;
  logic [PTR_W-1:0] search_idx;
  logic [PTR_W-1:0] sel;
  logic             locked;
  logic             any_ready;
  logic             rx_hs;
  int               cand;

  always_comb begin
    search_idx = rr_ptr;
    any_ready  = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_LINKS; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_LINKS;
      if (!any_ready && !empty[cand]) begin
        any_ready  = 1'b1;
        search_idx = PTR_W'(cand);
      end
    end
  end

  assign sel                  = locked ? grant_q : search_idx;
  assign interdevice_rx_valid = any_ready;
  assign interdevice_rx_flit  = head[sel];
  assign rx_hs                = interdevice_rx_valid & interdevice_rx_ready;

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_LINKS; k++) pop[k] = rx_hs && (int'(sel) == k);
  end

  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      locked  <= 1'b0;
    end else if (rx_hs) begin
      rr_ptr <= (int'(sel) == NUM_LINKS - 1) ? '0 : sel + PTR_W'(1);
      locked <= 1'b0;
    end else if (interdevice_rx_valid) begin
      grant_q <= sel;
      locked  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_interdevice_link_hub.sv
module tb_interdevice_link_hub;
  import interdevice_link_hub_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;
`ifdef INTERDEVICE_BROADCAST_ACCEPT_EN
  localparam int BCAST = 1;
`else
  localparam int BCAST = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            cpuclk = 1'b0;
  logic            rst;
  node_id_t        this_node_id;
  flit_t           interdevice_tx_flit;
  logic            interdevice_tx_valid;
  logic            interdevice_tx_ready;
  flit_t           interdevice_rx_flit;
  logic            interdevice_rx_valid;
  logic            interdevice_rx_ready;
  flit_t           flit_rx [N];
  logic [N-1:0]    flit_rx_valid;
  logic [N-1:0]    flit_rx_ready;
  flit_t           flit_tx;
  logic [N-1:0]    flit_tx_valid;
  logic [N-1:0]    flit_tx_ready;
  logic [15:0]     drop_count [N];

  always #5 cpuclk = ~cpuclk;

  interdevice_link_hub #(.NUM_LINKS(N), .FIFO_DEPTH(DEPTH)) dut (
    .cpuclk               (cpuclk),
    .rst                  (rst),
    .this_node_id         (this_node_id),
    .interdevice_tx_flit  (interdevice_tx_flit),
    .interdevice_tx_valid (interdevice_tx_valid),
    .interdevice_tx_ready (interdevice_tx_ready),
    .interdevice_rx_flit  (interdevice_rx_flit),
    .interdevice_rx_valid (interdevice_rx_valid),
    .interdevice_rx_ready (interdevice_rx_ready),
    .flit_rx              (flit_rx),
    .flit_rx_valid        (flit_rx_valid),
    .flit_rx_ready        (flit_rx_ready),
    .flit_tx              (flit_tx),
    .flit_tx_valid        (flit_tx_valid),
    .flit_tx_ready        (flit_tx_ready),
    .drop_count           (drop_count)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [31:0] exp_q [N][$];
  int          m_drops [N];
  int          m_rr;
  bit          m_locked;
  int          m_grant;
  int          delivered;
  bit [N-1:0]  last_acc;
  int          deliv_src [$];

  function automatic logic [31:0] make_flit(int src, int dst, int payload, bit good);
    logic [31:0] r;
    int cs;
    cs = ((src * 16 + dst) ^ (payload / 256) ^ (payload % 256)) % 256;
    if (!good) cs = cs ^ 90;
    r = (src % 16) * 32'h1000_0000 + (dst % 16) * 32'h0100_0000 +
        (payload % 65536) * 256 + cs;
    return r;
  endfunction

  function automatic bit flit_wanted(logic [31:0] f);
    int src, dst, pl, cs;
    src = int'(f[31:28]);
    dst = int'(f[27:24]);
    pl  = int'(f[23:8]);
    cs  = int'(f[7:0]);
    if (cs != (((src * 16 + dst) ^ (pl / 256) ^ (pl % 256)) % 256)) return 1'b0;
    if (dst == 3) return 1'b1;
    return (dst == 15) && (BCAST == 1);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      m_drops[k] = 0;
    end
    m_rr      = 0;
    m_locked  = 1'b0;
    m_grant   = 0;
    delivered = 0;
    last_acc  = '0;
    deliv_src.delete();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst                  = 1'b1;
    interdevice_tx_flit  = '0;
    interdevice_tx_valid = 1'b0;
    interdevice_rx_ready = 1'b0;
    flit_rx_valid        = '0;
    flit_tx_ready        = '0;
    for (int k = 0; k < N; k++) flit_rx[k] = '0;
    repeat (2) @(posedge cpuclk);
    @(negedge cpuclk);
    rst = 1'b0;
    model_reset();
    @(posedge cpuclk);
    #1;
  endtask

  // One clock: compare RX-side outputs with the model mid-cycle, then
  // advance the model with the transfers the specification implies.
  task automatic step();
    bit         vld;
    int         sel;
    bit [N-1:0] rdy_exp;
    bit         pop_hs;
    @(negedge cpuclk);
    vld = 1'b0;
    sel = 0;
    for (int k = 0; k < N; k++) rdy_exp[k] = (exp_q[k].size() < DEPTH);
    if (m_locked) begin
      vld = 1'b1;
      sel = m_grant;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (!vld && exp_q[c].size() > 0) begin
          vld = 1'b1;
          sel = c;
        end
      end
    end
    checks++;
    if (interdevice_rx_valid !== vld) begin
      errors++;
      $display("FAIL rx_valid t=%0t got=%b exp=%b", $time, interdevice_rx_valid, vld);
    end
    if (vld) begin
      checks++;
      if (interdevice_rx_flit !== exp_q[sel][0]) begin
        errors++;
        $display("FAIL rx_flit t=%0t got=%h exp=%h", $time, interdevice_rx_flit, exp_q[sel][0]);
      end
    end
    checks++;
    if (flit_rx_ready !== rdy_exp) begin
      errors++;
      $display("FAIL flit_rx_ready t=%0t got=%b exp=%b", $time, flit_rx_ready, rdy_exp);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (drop_count[k] !== 16'(m_drops[k])) begin
        errors++;
        $display("FAIL drop_count[%0d] t=%0t got=%0d exp=%0d", k, $time, drop_count[k], m_drops[k]);
      end
    end
    pop_hs = vld && interdevice_rx_ready;
    if (pop_hs) deliv_src.push_back(int'(interdevice_rx_flit.src_id));
    for (int k = 0; k < N; k++) last_acc[k] = flit_rx_valid[k] && rdy_exp[k];
    @(posedge cpuclk);
    if (pop_hs) begin
      void'(exp_q[sel].pop_front());
      m_rr      = (sel + 1) % N;
      m_locked  = 1'b0;
      delivered++;
    end else if (vld) begin
      m_locked = 1'b1;
      m_grant  = sel;
    end
    for (int k = 0; k < N; k++) begin
      if (last_acc[k]) begin
        if (flit_wanted(flit_rx[k])) exp_q[k].push_back(flit_rx[k]);
        else if (m_drops[k] < 65535) m_drops[k]++;
      end
    end
    #1;
  endtask

  // Present a flit on link k and hold it until accepted (bounded).
  task automatic send_link(int k, logic [31:0] f);
    bit done;
    done = 1'b0;
    flit_rx[k]       = f;
    flit_rx_valid[k] = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      step();
      done = last_acc[k];
    end
    flit_rx_valid[k] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_link%0d_timeout got=not_accepted exp=accepted", k);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks += 3;
    if (flit_rx_ready !== 2'b11) begin
      errors++; $display("FAIL reset_rx_ready got=%b exp=11", flit_rx_ready);
    end
    if (interdevice_rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rx_valid got=%b exp=0", interdevice_rx_valid);
    end
    if (drop_count[0] !== 16'd0 || drop_count[1] !== 16'd0) begin
      errors++; $display("FAIL reset_drop got=%0d,%0d exp=0,0", drop_count[0], drop_count[1]);
    end
    interdevice_tx_valid = 1'b1;
    #1;
    checks++;
    if (flit_tx_valid !== 2'b11) begin
      errors++; $display("FAIL reset_tx_follow got=%b exp=11", flit_tx_valid);
    end
    interdevice_tx_valid = 1'b0;
    // Load one good flit and one drop, then reset asynchronously mid-cycle.
    flit_rx[0]    = make_flit(0, 3, 16'h0A0B, 1'b1);
    flit_rx[1]    = make_flit(1, 3, 16'h0C0D, 1'b0);
    flit_rx_valid = 2'b11;
    step();
    flit_rx_valid = 2'b00;
    step();
    rst = 1'b1;
    #1;
    checks += 3;
    if (interdevice_rx_valid !== 1'b0) begin
      errors++; $display("FAIL async_rst_rx_valid got=%b exp=0", interdevice_rx_valid);
    end
    if (flit_rx_ready !== 2'b00) begin
      errors++; $display("FAIL async_rst_rx_ready got=%b exp=00", flit_rx_ready);
    end
    if (drop_count[1] !== 16'd0) begin
      errors++; $display("FAIL async_rst_drop got=%0d exp=0", drop_count[1]);
    end
    apply_reset();
  endtask

  task automatic test_latency();
    logic [31:0] f;
    apply_reset();
    interdevice_rx_ready = 1'b1;
    f = make_flit(0, 3, 16'h1234, 1'b1);
    flit_rx[0]       = f;
    flit_rx_valid[0] = 1'b1;
    step();
    flit_rx_valid[0] = 1'b0;
    checks++;
    if (interdevice_rx_valid !== 1'b1 || interdevice_rx_flit !== f) begin
      errors++;
      $display("FAIL latency got=%b/%h exp=1/%h", interdevice_rx_valid, interdevice_rx_flit, f);
    end
    step();
    step();
    checks++;
    if (delivered !== 1) begin
      errors++; $display("FAIL latency_delivered got=%0d exp=1", delivered);
    end
  endtask

  task automatic test_drops();
    apply_reset();
    interdevice_rx_ready = 1'b1;
    send_link(1, make_flit(1, 3, 16'h5555, 1'b0));
    send_link(1, make_flit(1, 5, 16'h6666, 1'b1));
    repeat (3) step();
    checks += 2;
    if (drop_count[1] !== 16'd2) begin
      errors++; $display("FAIL drop_two got=%0d exp=2", drop_count[1]);
    end
    if (delivered !== 0) begin
      errors++; $display("FAIL drop_no_delivery got=%0d exp=0", delivered);
    end
    flit_rx[1]       = make_flit(1, 3, 16'h7777, 1'b0);
    flit_rx_valid[1] = 1'b1;
    repeat (65540) @(posedge cpuclk);
    #1;
    flit_rx_valid[1] = 1'b0;
    m_drops[1] = 65535;
    checks++;
    if (drop_count[1] !== 16'hFFFF) begin
      errors++; $display("FAIL drop_saturate got=%h exp=ffff", drop_count[1]);
    end
    repeat (2) step();
  endtask

  task automatic test_fifo_full();
    apply_reset();
    for (int n = 0; n < 4; n++) send_link(0, make_flit(0, 3, 16'h0100 + n, 1'b1));
    checks++;
    if (flit_rx_ready[0] !== 1'b0) begin
      errors++; $display("FAIL full_ready got=%b exp=0", flit_rx_ready[0]);
    end
    flit_rx[0]       = make_flit(0, 3, 16'h0104, 1'b1);
    flit_rx_valid[0] = 1'b1;
    repeat (3) step();
    flit_rx_valid[0] = 1'b0;
    checks++;
    if (drop_count[0] !== 16'd0) begin
      errors++; $display("FAIL full_not_counted got=%0d exp=0", drop_count[0]);
    end
    interdevice_rx_ready = 1'b1;
    repeat (6) step();
    checks++;
    if (delivered !== 4) begin
      errors++; $display("FAIL full_delivered got=%0d exp=4", delivered);
    end
  endtask

  task automatic test_round_robin();
    flit_t f0;
    int    exp_order [4];
    exp_order = '{0, 1, 0, 1};
    apply_reset();
    for (int n = 0; n < 2; n++) begin
      flit_rx[0]    = make_flit(0, 3, 16'h2000 + n, 1'b1);
      flit_rx[1]    = make_flit(1, 3, 16'h3000 + n, 1'b1);
      flit_rx_valid = 2'b11;
      step();
    end
    flit_rx_valid = 2'b00;
    step();
    interdevice_rx_ready = 1'b1;
    step();
    interdevice_rx_ready = 1'b0;
    f0 = interdevice_rx_flit;
    for (int t = 0; t < 3; t++) begin
      step();
      checks++;
      if (interdevice_rx_valid !== 1'b1 || interdevice_rx_flit !== f0) begin
        errors++;
        $display("FAIL rr_stall_stable got=%b/%h exp=1/%h", interdevice_rx_valid, interdevice_rx_flit, f0);
      end
    end
    interdevice_rx_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (deliv_src.size() != 4) begin
      errors++; $display("FAIL rr_count got=%0d exp=4", deliv_src.size());
    end else begin
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (deliv_src[n] != exp_order[n]) begin
          errors++; $display("FAIL rr_order[%0d] got=L%0d exp=L%0d", n, deliv_src[n], exp_order[n]);
        end
      end
    end
  endtask

  task automatic test_tx();
    logic [N-1:0] exp_v;
    logic         exp_r;
    logic [31:0]  f;
    int           n0;
    apply_reset();
    f  = $urandom();
    n0 = 0;
    interdevice_tx_flit  = f;
    interdevice_tx_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      flit_tx_ready = (c == 4) ? 2'b10 : 2'b01;
      exp_v = (c == 1) ? 2'b11 : 2'b10;
      exp_r = (c == 4);
      @(negedge cpuclk);
      checks += 3;
      if (flit_tx_valid !== exp_v) begin
        errors++; $display("FAIL tx_valid c%0d got=%b exp=%b", c, flit_tx_valid, exp_v);
      end
      if (interdevice_tx_ready !== exp_r) begin
        errors++; $display("FAIL tx_ready c%0d got=%b exp=%b", c, interdevice_tx_ready, exp_r);
      end
      if (flit_tx !== f) begin
        errors++; $display("FAIL tx_flit c%0d got=%h exp=%h", c, flit_tx, f);
      end
      if (flit_tx_valid[0] && flit_tx_ready[0]) n0++;
      @(posedge cpuclk);
      #1;
    end
    flit_tx_ready = 2'b00;
    checks++;
    if (n0 != 1) begin
      errors++; $display("FAIL tx_link0_once got=%0d exp=1", n0);
    end
    #1;
    checks++;
    if (flit_tx_valid !== 2'b11) begin
      errors++; $display("FAIL tx_sent_cleared got=%b exp=11", flit_tx_valid);
    end
    interdevice_tx_valid = 1'b0;
  endtask

  task automatic test_tx_reset();
    apply_reset();
    interdevice_tx_flit  = $urandom();
    interdevice_tx_valid = 1'b1;
    flit_tx_ready        = 2'b01;
    @(posedge cpuclk);
    #1;
    flit_tx_ready = 2'b00;
    checks++;
    if (flit_tx_valid !== 2'b10) begin
      errors++; $display("FAIL tx_partial got=%b exp=10", flit_tx_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (flit_tx_valid !== 2'b11) begin
      errors++; $display("FAIL tx_rst_clear got=%b exp=11", flit_tx_valid);
    end
    @(negedge cpuclk);
    rst = 1'b0;
    @(posedge cpuclk);
    #1;
    checks++;
    if (flit_tx_valid !== 2'b11) begin
      errors++; $display("FAIL tx_after_rst got=%b exp=11", flit_tx_valid);
    end
    interdevice_tx_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_broadcast();
    int exp_del;
    int exp_drop;
    exp_del  = BCAST;
    exp_drop = 1 - BCAST;
    apply_reset();
    interdevice_rx_ready = 1'b1;
    send_link(0, make_flit(0, 15, 16'hBCBC, 1'b1));
    repeat (2) step();
    checks += 2;
    if (delivered != exp_del) begin
      errors++; $display("FAIL bcast_delivered got=%0d exp=%0d", delivered, exp_del);
    end
    if (drop_count[0] !== 16'(exp_drop)) begin
      errors++; $display("FAIL bcast_drop got=%0d exp=%0d", drop_count[0], exp_drop);
    end
  endtask

  task automatic test_random();
    int dsts [5];
    dsts = '{3, 3, 3, 5, 15};
    apply_reset();
    for (int t = 0; t < 600; t++) begin
      interdevice_rx_ready = ($urandom_range(0, 9) < 6);
      for (int k = 0; k < N; k++) begin
        if (!flit_rx_valid[k] || last_acc[k]) begin
          flit_rx_valid[k] = ($urandom_range(0, 9) < 6);
          flit_rx[k] = make_flit(k, dsts[$urandom_range(0, 4)],
                                 int'($urandom_range(0, 65535)),
                                 ($urandom_range(0, 19) != 0));
        end
      end
      step();
    end
    flit_rx_valid        = '0;
    interdevice_rx_ready = 1'b1;
    repeat (12) step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    this_node_id = 4'd3;
    test_reset();
    test_latency();
    test_drops();
    test_fifo_full();
    test_round_robin();
    test_tx();
    test_tx_reset();
    test_broadcast();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
